lcd_800_480_timing: RTL and testbench

Display timing generator for the 800x480 parallel RGB LCD. It runs in the pixel clock domain driven by the board PLL and takes that PLL's lock indication as an input. It produces the hsync, vsync and data-enable strobes, the current pixel coordinates and a frame-start pulse. It holds the panel idle until the clock is stable, and raises the display-on signal only after a fixed number of clean frames.

---
 rtl/lcd_800_480_timing.sv | 235 +++++++++++++++++++++++
 tb/tb_lcd_800_480_timing.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_800_480_timing.sv
// lcd_800_480_timing
// Pixel-clock-domain timing generator for an 800x480 parallel RGB panel.
// Waits for a stable PLL lock, scans the raster (active, front porch, sync,
// back porch on each axis) and enables the display after a few clean frames.
// All outputs are registered and derived from the previous clock's counters.

module lcd_800_480_timing #(
  parameter int   H_ACTIVE         = 800,
  parameter int   H_FRONT          = 40,
  parameter int   H_SYNC           = 48,
  parameter int   H_BACK           = 40,
  parameter int   V_ACTIVE         = 480,
  parameter int   V_FRONT          = 13,
  parameter int   V_SYNC           = 3,
  parameter int   V_BACK           = 32,
  parameter logic SYNC_ACTIVE_HIGH = 1'b0,
  parameter int   SETTLE_CYCLES    = 1024,
  parameter int   START_FRAMES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       disp_on
);

  // Raster geometry; totals must not exceed 1024 so 10-bit counters suffice.
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Window bounds are 11 bits wide so an end bound of 1024 is still exact.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  // Settle counter only has to reach SETTLE_CYCLES-1.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  // Frame counter saturates at START_FRAMES (expected to stay below 256).
  localparam logic [7:0] FRAME_SAT = 8'(START_FRAMES);

  localparam logic SYNC_ON  = SYNC_ACTIVE_HIGH;
  localparam logic SYNC_OFF = ~SYNC_ACTIVE_HIGH;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          lock_meta;
  logic          lock_s;
  logic [SW-1:0] settle_cnt;
  logic [SW-1:0] settle_next;
  logic [9:0]    h_cnt;
  logic [9:0]    h_next;
  logic [9:0]    v_cnt;
  logic [9:0]    v_next;
  logic [7:0]    frame_cnt;
  logic [7:0]    frame_next;

  logic          h_win;
  logic          v_win;
  logic          active;

  logic          hsync_next;
  logic          vsync_next;
  logic          de_next;
  logic [9:0]    x_next;
  logic [9:0]    y_next;
  logic          frame_start_next;
  logic          disp_on_next;

  // Two-flop synchronizer bringing the asynchronous PLL lock into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // FSM state and scan counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      h_cnt      <= 10'd0;
      v_cnt      <= 10'd0;
      frame_cnt  <= 8'd0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      h_cnt      <= h_next;
      v_cnt      <= v_next;
      frame_cnt  <= frame_next;
    end
  end

  // Next-state and counter logic; everything outside RUN holds counters at 0.
  always_comb begin
    state_next  = state;
    settle_next = '0;
    h_next      = 10'd0;
    v_next      = 10'd0;
    frame_next  = 8'd0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = SETTLE;
        end else begin
          state_next = WAIT_LOCK;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          // Any lock loss seen here restarts the whole settle sequence.
          state_next = WAIT_LOCK;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_next = RUN;
        end else begin
          state_next  = SETTLE;
          settle_next = settle_cnt + {{(SW-1){1'b0}}, 1'b1};
        end
      end
      RUN: begin
        if (!lock_s) begin
          // Abort the frame; counters drop to 0 through the defaults.
          state_next = WAIT_LOCK;
        end else begin
          state_next = RUN;
          if (h_cnt == H_LAST) begin
            h_next = 10'd0;
            if (v_cnt == V_LAST) begin
              v_next = 10'd0;
            end else begin
              v_next = v_cnt + 10'd1;
            end
          end else begin
            h_next = h_cnt + 10'd1;
            v_next = v_cnt;
          end
          if ((h_cnt == H_LAST) && (v_cnt == V_LAST) && (frame_cnt != FRAME_SAT)) begin
            frame_next = frame_cnt + 8'd1;
          end else begin
            frame_next = frame_cnt;
          end
        end
      end
      default: begin
        state_next = WAIT_LOCK;
      end
    endcase
  end

  assign h_win  = ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
  assign v_win  = ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);
  assign active = ({1'b0, h_cnt} < H_ACT_END) && ({1'b0, v_cnt} < V_ACT_END);

  // Decode the current counters into the values the outputs take next clock.
  always_comb begin
    hsync_next       = SYNC_OFF;
    vsync_next       = SYNC_OFF;
    de_next          = 1'b0;
    x_next           = 10'd0;
    y_next           = 10'd0;
    frame_start_next = 1'b0;
    disp_on_next     = 1'b0;
    if (state == RUN) begin
      if (h_win) begin
        hsync_next = SYNC_ON;
      end else begin
        hsync_next = SYNC_OFF;
      end
      if (v_win) begin
        vsync_next = SYNC_ON;
      end else begin
        vsync_next = SYNC_OFF;
      end
      if (active) begin
        de_next = 1'b1;
        x_next  = h_cnt;
        y_next  = v_cnt;
      end else begin
        de_next = 1'b0;
        x_next  = 10'd0;
        y_next  = 10'd0;
      end
      frame_start_next = (h_cnt == 10'd0) && (v_cnt == 10'd0);
      disp_on_next     = (frame_cnt >= FRAME_SAT);
    end else begin
      hsync_next       = SYNC_OFF;
      vsync_next       = SYNC_OFF;
      frame_start_next = 1'b0;
      disp_on_next     = 1'b0;
    end
  end

  // Output registers; reset forces the idle levels immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      de          <= 1'b0;
      x           <= 10'd0;
      y           <= 10'd0;
      frame_start <= 1'b0;
      disp_on     <= 1'b0;
    end else begin
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      de          <= de_next;
      x           <= x_next;
      y           <= y_next;
      frame_start <= frame_start_next;
      disp_on     <= disp_on_next;
    end
  end

endmodule

// File: tb/tb_lcd_800_480_timing.sv
// Testbench for lcd_800_480_timing using a reduced raster so several frames
// fit in a short run. Expected outputs come from an arithmetic model: once
// lock has been stable long enough, the output at clock k is the pixel at
// offset (k - scan_start) within a repeating H_TOTAL x V_TOTAL raster.

module tb_lcd_800_480_timing;

  localparam int HA = 16;
  localparam int HF = 4;
  localparam int HS = 5;
  localparam int HB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 6;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int SC = 20;
  localparam int SF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;
  logic       disp_on;

  int checks = 0;
  int errors = 0;

  // Model state: clock index since reset release, clock where the current
  // continuous lock began (-1 when unlocked), clock where lock last fell.
  int k;
  int lock_start;
  int drop_edge;
  bit prev_lock;

  lcd_800_480_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_HIGH(1'b0), .SETTLE_CYCLES(SC), .START_FRAMES(SF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_lock(pll_lock),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .x(x),
    .y(y),
    .frame_start(frame_start),
    .disp_on(disp_on)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] outs();
    return {hsync, vsync, de, x, y, frame_start, disp_on};
  endfunction

  function automatic logic [24:0] idle_vec();
    return {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
  endfunction

  // Expected outputs p clocks after the first scanned pixel.
  function automatic logic [24:0] scan_vec(input int p);
    int f;
    int q;
    int h;
    int v;
    logic hs;
    logic vs;
    logic d;
    logic fs;
    logic on;
    logic [9:0] xx;
    logic [9:0] yy;
    f  = p / FT;
    q  = p % FT;
    h  = q % HT;
    v  = q / HT;
    d  = (h < HA) && (v < VA);
    hs = !((h >= HA + HF) && (h < HA + HF + HS));
    vs = !((v >= VA + VF) && (v < VA + VF + VS));
    xx = d ? 10'(h) : 10'd0;
    yy = d ? 10'(v) : 10'd0;
    fs = (h == 0) && (v == 0);
    on = (f >= SF);
    return {hs, vs, d, xx, yy, fs, on};
  endfunction

  task automatic check_eq(input string tag, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s clk=%0d got=%h exp=%h (hs,vs,de,x,y,fs,on)", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k          = 0;
    lock_start = -1;
    drop_edge  = -100;
    prev_lock  = 1'b0;
  endtask

  // Drive one clock with the given lock level and check the resulting outputs.
  // Called between edges; returns at the following negedge.
  task automatic step(input logic lv);
    pll_lock = lv;
    @(posedge clk);
    k++;
    if (lv && !prev_lock) lock_start = k;
    if (!lv && prev_lock) drop_edge = k;
    if (!lv) lock_start = -1;
    prev_lock = lv;
    #1;
    // The outputs may still show the aborted scan for a few clocks after a drop.
    if (!(k >= drop_edge && k <= drop_edge + 2)) begin
      if (lock_start < 0 || k < lock_start + SC + 3) begin
        check_eq("idle", outs(), idle_vec());
      end else begin
        check_eq("scan", outs(), scan_vec(k - (lock_start + SC + 3)));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int guard;
    model_reset();
    rst_n    = 1'b0;
    pll_lock = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("rst_idle", outs(), idle_vec());
    end
    rst_n = 1'b1;
    model_reset();

    // Settle, then three-plus frames so disp_on rises.
    repeat (SC + 3 + 3 * FT + 40) step(1'b1);

    // Drop lock at line 2, pixel 5 of a frame, then restore.
    guard = 0;
    while ((((k + 1) - (lock_start + SC + 3)) % FT != 2 * HT + 5) && guard < FT + 2) begin
      step(1'b1);
      guard++;
    end
    repeat (4) step(1'b0);
    repeat (SC + 3 + FT + 20) step(1'b1);

    // Lock glitch of 3 clocks in the middle of the settle window.
    repeat (3) step(1'b0);
    repeat (10) step(1'b1);
    repeat (3) step(1'b0);
    repeat (SC + 3 + FT) step(1'b1);

    // Random lock holds and drops of varying lengths.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 2 * FT)) step(1'b1);
      repeat ($urandom_range(1, 6)) step(1'b0);
    end
    repeat (SC + 3 + FT) step(1'b1);

    // Asynchronous reset in the middle of scanning.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", outs(), idle_vec());
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_hold", outs(), idle_vec());
    end
    rst_n = 1'b1;
    model_reset();
    repeat (SC + 3 + FT + 10) step(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
